// File: rtl/psum_accum.sv
// Window accumulator for the PE datapath: sums adder-tree beats, then rounds, shifts,
// optionally ReLUs and saturates one result per window behind a hold/ready handshake.
module psum_accum #(
  parameter int IN_WID  = 8,
  parameter int ACC_WID = 20,
  parameter int OUT_WID = 8,
  parameter int SHIFT   = 4,
  parameter bit RELU_EN = 1'b1,
  parameter int CNT_WID = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                status_in,
  input  logic signed [IN_WID-1:0]  data_in,
  input  logic                      out_ready,
  output logic [1:0]                status_out,
  output logic signed [OUT_WID-1:0] data_out,
  output logic [CNT_WID-1:0]        beat_cnt,
  output logic [1:0]                err
);

  // PE_STATE encoding shared with the adder stage
  localparam logic [1:0] ST_INVALID = 2'd0;
  localparam logic [1:0] ST_VALID   = 2'd1;
  localparam logic [1:0] ST_FIN     = 2'd2;
  localparam logic [1:0] ST_COMPL   = 2'd3;

  localparam logic [ACC_WID:0] RND = (ACC_WID+1)'((1 << SHIFT) >> 1);

  typedef enum logic [1:0] {ACCUM, RES, RES_C, CMPL} state_t;

  state_t                      state, state_nx;
  logic signed [ACC_WID-1:0]   acc, acc_nx;
  logic [CNT_WID-1:0]          cnt_nx, cnt_inc;
  logic signed [OUT_WID-1:0]   dout_nx, res;
  logic [1:0]                  err_nx;
  logic signed [ACC_WID-1:0]   sum;
  logic signed [ACC_WID:0]     rnd_sum, shifted;

  assign sum     = acc + {{(ACC_WID-IN_WID){data_in[IN_WID-1]}}, data_in};
  assign cnt_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

  // Rounding is done one bit wider so the bias cannot wrap a near-max sum.
  assign rnd_sum = {sum[ACC_WID-1], sum} + $signed(RND);
  assign shifted = rnd_sum >>> SHIFT;

  always_comb begin
    res = shifted[OUT_WID-1:0];
    if (RELU_EN && shifted[ACC_WID]) begin
      res = '0;
    end else if (!(&shifted[ACC_WID:OUT_WID-1]) && (|shifted[ACC_WID:OUT_WID-1])) begin
      res = shifted[ACC_WID] ? {1'b1, {(OUT_WID-1){1'b0}}} : {1'b0, {(OUT_WID-1){1'b1}}};
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = beat_cnt;
    dout_nx  = data_out;
    err_nx   = err;
    unique case (state)
      ACCUM, RES: begin
        if (state == RES && out_ready) state_nx = ACCUM;
        unique case (status_in)
          ST_VALID: begin
            acc_nx = sum;
            cnt_nx = cnt_inc;
          end
          ST_FIN: begin
            acc_nx = '0;
            cnt_nx = '0;
            if (state == ACCUM || out_ready) begin
              dout_nx  = res;
              state_nx = RES;
            end else begin
              err_nx[0] = 1'b1;
            end
          end
          ST_COMPL: begin
            acc_nx = '0;
            cnt_nx = '0;
            if (beat_cnt != '0) err_nx[1] = 1'b1;
            // a pending, unaccepted result must leave before COMPL is shown
            state_nx = (state == RES && !out_ready) ? RES_C : CMPL;
          end
          default: ;
        endcase
      end
      RES_C: begin
        if (status_in == ST_VALID || status_in == ST_FIN) err_nx[0] = 1'b1;
        if (out_ready) state_nx = CMPL;
      end
      CMPL: begin
        if (status_in != ST_INVALID) err_nx[0] = 1'b1;
        if (out_ready) state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      data_out <= '0;
      err      <= '0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      beat_cnt <= cnt_nx;
      data_out <= dout_nx;
      err      <= err_nx;
    end
  end

  always_comb begin
    unique case (state)
      RES, RES_C: status_out = ST_FIN;
      CMPL:       status_out = ST_COMPL;
      default:    status_out = ST_INVALID;
    endcase
  end

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: directed window scenarios with literal results, then random
// traffic against a behavioural window/handshake model on two DUTs (ReLU on and off).
module tb_psum_accum;

  localparam logic [1:0] INV = 2'd0, VLD = 2'd1, FIN = 2'd2, CPL = 2'd3;

  logic              clk, rst_n;
  logic [1:0]        status_in;
  logic signed [7:0] data_in;
  logic              out_ready;
  logic [1:0]        st_a, st_b, err_a, err_b;
  logic signed [7:0] do_a, do_b;
  logic [15:0]       bc_a, bc_b;

  int total = 0;
  int bad   = 0;

  psum_accum dut (
    .clk(clk), .reset(rst_n), .status_in(status_in), .data_in(data_in),
    .out_ready(out_ready), .status_out(st_a), .data_out(do_a),
    .beat_cnt(bc_a), .err(err_a)
  );

  psum_accum #(.RELU_EN(1'b0)) dut_nr (
    .clk(clk), .reset(rst_n), .status_in(status_in), .data_in(data_in),
    .out_ready(out_ready), .status_out(st_b), .data_out(do_b),
    .beat_cnt(bc_b), .err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_acc, m_cnt, m_dout, m_dnr, fin_v;
  bit m_res, m_cq, m_cpl, drop, n_res, n_cq, n_cpl;
  bit [1:0] m_err;

  function automatic int wrap20(input int x);
    return (x <<< 12) >>> 12;
  endfunction

  function automatic int requant(input int f, input bit relu);
    int v;
    v = (f + 8) >>> 4;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_cnt = 0; m_dout = 0; m_dnr = 0;
      m_res = 0; m_cq = 0; m_cpl = 0; m_err = 0;
    end else begin
      drop  = m_cq || m_cpl;
      n_res = m_res && !out_ready;
      n_cq  = m_cq && !out_ready;
      n_cpl = (m_cpl && !out_ready) || (m_cq && out_ready);
      case (status_in)
        VLD: if (drop) m_err[0] = 1'b1;
             else begin
               m_acc = wrap20(m_acc + int'(data_in));
               if (m_cnt < 65535) m_cnt++;
             end
        FIN: if (drop) m_err[0] = 1'b1;
             else begin
               fin_v = wrap20(m_acc + int'(data_in));
               m_acc = 0; m_cnt = 0;
               if (!m_res || out_ready) begin
                 m_dout = requant(fin_v, 1'b1);
                 m_dnr  = requant(fin_v, 1'b0);
                 n_res  = 1'b1;
               end else m_err[0] = 1'b1;
             end
        CPL: if (m_cpl) m_err[0] = 1'b1;
             else if (!m_cq) begin
               if (m_cnt != 0) m_err[1] = 1'b1;
               m_acc = 0; m_cnt = 0;
               if (m_res && !out_ready) n_cq = 1'b1;
               else n_cpl = 1'b1;
             end
        default: ;
      endcase
      m_res = n_res; m_cq = n_cq; m_cpl = n_cpl;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("status", int'(st_a), m_cpl ? 3 : (m_res ? 2 : 0));
      check("status_nr", int'(st_b), m_cpl ? 3 : (m_res ? 2 : 0));
      check("data_out", int'(do_a), m_dout);
      check("data_out_nr", int'(do_b), m_dnr);
      check("beat_cnt", int'(bc_a), m_cnt);
      check("beat_cnt_nr", int'(bc_b), m_cnt);
      check("err", int'(err_a), int'(m_err));
      check("err_nr", int'(err_b), int'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [1:0] st, input int d, input logic rdy);
    status_in = st;
    data_in   = 8'(d);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    status_in = INV; data_in = 0; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_status", int'(st_a), 0);
    check("rst_data", int'(do_a), 0);
    check("rst_err", int'(err_a), 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic window: (96+8)>>>4 = 6
    cyc(VLD, 16, 1); cyc(VLD, 32, 1);
    check("t1_cnt", int'(bc_a), 2);
    cyc(FIN, 48, 1);
    check("t1_status", int'(st_a), 2);
    check("t1_data", int'(do_a), 6);
    cyc(INV, 0, 1);
    check("t1_idle", int'(st_a), 0);
    check("t1_cnt0", int'(bc_a), 0);

    // negative window: -7 clamped by ReLU, raw on the other instance
    cyc(VLD, -100, 1); cyc(FIN, -20, 1);
    check("t2_relu", int'(do_a), 0);
    check("t2_norelu", int'(do_b), -7);
    cyc(INV, 0, 1);

    // saturation: 20*127 = 2540 -> 159 -> 127
    for (int i = 0; i < 19; i++) cyc(VLD, 127, 1);
    check("t3_cnt", int'(bc_a), 19);
    cyc(FIN, 127, 1);
    check("t3_sat", int'(do_a), 127);
    cyc(INV, 0, 1);

    // overrun while result is held
    cyc(VLD, 16, 0); cyc(VLD, 32, 0); cyc(FIN, 48, 0);
    check("t4_data", int'(do_a), 6);
    cyc(VLD, 0, 0); cyc(FIN, 160, 0);
    check("t4_err0", int'(err_a[0]), 1);
    check("t4_hold", int'(do_a), 6);
    check("t4_stat", int'(st_a), 2);
    cyc(INV, 0, 1);
    check("t4_idle", int'(st_a), 0);

    // COMPL behind a pending result with a partial window
    cyc(VLD, 16, 0); cyc(VLD, 32, 0); cyc(FIN, 48, 0);
    cyc(VLD, 3, 0); cyc(VLD, 4, 0);
    check("t5_cnt", int'(bc_a), 2);
    cyc(CPL, 0, 0);
    check("t5_err1", int'(err_a[1]), 1);
    check("t5_resc", int'(st_a), 2);
    check("t5_cnt0", int'(bc_a), 0);
    cyc(INV, 0, 1);
    check("t5_compl", int'(st_a), 3);
    cyc(INV, 0, 1);
    check("t5_idle", int'(st_a), 0);

    // async reset in the middle of a window
    cyc(VLD, 5, 1); cyc(VLD, 6, 1);
    status_in = INV;
    #2 rst_n = 1'b0;
    #1;
    check("t6_status", int'(st_a), 0);
    check("t6_data", int'(do_a), 0);
    check("t6_err", int'(err_a), 0);
    check("t6_cnt", int'(bc_a), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(VLD, 16, 1); cyc(FIN, 16, 1);
    check("t6_fresh", int'(do_a), 2);
    cyc(INV, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      cyc((r < 20) ? INV : (r < 70) ? VLD : (r < 90) ? FIN : CPL,
          int'($urandom_range(0, 255)), ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
